// File: rtl/bcd_serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// bcd_serial_sub_pkg
// Shared definitions for the digit-serial BCD subtractor: FSM state encoding,
// BCD digit width and radix constants, and a digit validity helper.
// -----------------------------------------------------------------------------
package bcd_serial_sub_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [4:0] BCD_RADIX = 5'd10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SUB   = 3'd2,
        ST_NEG   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // True when a 4-bit nibble is not a legal BCD digit.
    function automatic logic digit_invalid(input logic [3:0] d);
        return (d > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// -----------------------------------------------------------------------------
// bcd_digit_sub
// Combinational single-digit BCD subtractor: d = x - y - bin, wrapped into
// 0..9 by adding the radix when the difference goes negative.
// Ports:
//   i_x    [3:0]  minuend digit (0..9)
//   i_y    [3:0]  subtrahend digit (0..9)
//   i_bin         borrow in
//   o_d    [3:0]  result digit (0..9)
//   o_bout        borrow out
// -----------------------------------------------------------------------------
module bcd_digit_sub
    import bcd_serial_sub_pkg::*;
(
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    input  logic       i_bin,
    output logic [3:0] o_d,
    output logic       o_bout
);

    logic [4:0] w_t;
    logic [4:0] w_fix;

    // Five-bit two's-complement difference; bit 4 set means it went negative
    // (range is -10..9, so it never wraps past the sign bit).
    always_comb begin
        w_t   = {1'b0, i_x} - {1'b0, i_y} - {4'd0, i_bin};
        w_fix = w_t + BCD_RADIX;
        if (w_t[4]) begin
            o_d    = w_fix[3:0];
            o_bout = 1'b1;
        end else begin
            o_d    = w_t[3:0];
            o_bout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_sub.sv
// -----------------------------------------------------------------------------
// bcd_serial_sub
// Digit-serial NDIG-digit BCD subtractor producing |A-B| in sign-magnitude.
// One digit per clock, least significant digit first. A negative result is
// first formed as the ten's complement and then converted to magnitude by a
// second pass (0 - diff) through the same digit subtractor.
// Ports:
//   clk                 clock, rising edge
//   rst                 synchronous active-high reset
//   start               operation request, honoured only in IDLE
//   a    [4*NDIG-1:0]   minuend, packed BCD, digit 0 = LSD
//   b    [4*NDIG-1:0]   subtrahend, same packing
//   busy                operation in progress
//   done                one-cycle result-valid pulse
//   diff [4*NDIG-1:0]   magnitude of A-B, packed BCD
//   neg                 A < B
//   invalid             a latched operand digit exceeded 9
// -----------------------------------------------------------------------------
module bcd_serial_sub
    import bcd_serial_sub_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DIGIT_W*NDIG-1:0] a,
    input  logic [DIGIT_W*NDIG-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*NDIG-1:0] diff,
    output logic                    neg,
    output logic                    invalid
);

    localparam int W     = DIGIT_W * NDIG;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_diff;
    logic [IDX_W-1:0] r_idx;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;
    logic             r_neg;
    logic             r_invalid;

    logic             w_any_bad;
    logic [3:0]       w_x;
    logic [3:0]       w_y;
    logic [3:0]       w_d;
    logic             w_bout;
    logic             w_last;

    // Scan every latched operand digit for non-BCD codes.
    always_comb begin
        w_any_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (digit_invalid(r_a[i*DIGIT_W +: DIGIT_W]) ||
                digit_invalid(r_b[i*DIGIT_W +: DIGIT_W])) begin
                w_any_bad = 1'b1;
            end else begin
                w_any_bad = w_any_bad;
            end
        end
    end

    // Operand mux: SUB pass uses a_k - b_k, NEG pass uses 0 - diff_k.
    always_comb begin
        if (r_state == ST_NEG) begin
            w_x = 4'd0;
            w_y = r_diff[r_idx*DIGIT_W +: DIGIT_W];
        end else begin
            w_x = r_a[r_idx*DIGIT_W +: DIGIT_W];
            w_y = r_b[r_idx*DIGIT_W +: DIGIT_W];
        end
    end

    assign w_last = (r_idx == LAST_IDX);

    bcd_digit_sub u_digit (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // Control FSM with registered outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_diff    <= '0;
            r_idx     <= IDX_ZERO;
            r_borrow  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_neg     <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_borrow  <= 1'b0;
                        r_idx     <= IDX_ZERO;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_neg     <= 1'b0;
                        r_invalid <= 1'b0;
                        r_state   <= ST_CHECK;
                    end else begin
                        r_done    <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (w_any_bad) begin
                        r_diff    <= '0;
                        r_neg     <= 1'b0;
                        r_invalid <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_invalid <= 1'b0;
                        r_state   <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    r_diff[r_idx*DIGIT_W +: DIGIT_W] <= w_d;
                    if (w_last) begin
                        // A final borrow means the result is 10^NDIG - |A-B|.
                        if (w_bout) begin
                            r_neg    <= 1'b1;
                            r_borrow <= 1'b0;
                            r_idx    <= IDX_ZERO;
                            r_state  <= ST_NEG;
                        end else begin
                            r_neg    <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end else begin
                        r_borrow <= w_bout;
                        r_idx    <= r_idx + IDX_ONE;
                    end
                end
                ST_NEG: begin
                    r_diff[r_idx*DIGIT_W +: DIGIT_W] <= w_d;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_borrow <= w_bout;
                        r_idx    <= r_idx + IDX_ONE;
                    end
                end
                ST_DONE: begin
                    // start is deliberately not sampled here.
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign diff    = r_diff;
    assign neg     = r_neg;
    assign invalid = r_invalid;

endmodule

// File: tb/tb_bcd_serial_sub.sv
// -----------------------------------------------------------------------------
// tb_bcd_serial_sub
// Scoreboard bench: each issued operation pushes its hand-computed result and
// latency; a monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_bcd_serial_sub;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;
    localparam int P    = 10;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         neg;
    logic         invalid;

    typedef struct {
        logic [W-1:0] diff;
        logic         neg;
        logic         inv;
        int           lat;
        time          t0;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    bcd_serial_sub #(.NDIG(NDIG)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .neg     (neg),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #(P/2) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compare every done pulse against the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                int   lat;
                e   = sb_q.pop_front();
                lat = int'(($time - e.t0 + P/2) / P);
                chk("diff",    {16'd0, diff},    {16'd0, e.diff});
                chk("neg",     {31'd0, neg},     {31'd0, e.neg});
                chk("invalid", {31'd0, invalid}, {31'd0, e.inv});
                chk("latency", lat,              e.lat);
                chk("busy_in_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ed, input logic en, input logic ei,
                         input int el, input bit push);
        exp_t e;
        @(posedge clk); #1;
        a = ia; b = ib; start = 1'b1;
        @(posedge clk);
        e.diff = ed; e.neg = en; e.inv = ei; e.lat = el; e.t0 = $time;
        if (push) sb_q.push_back(e);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            chk("timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},    {31'd0, busy},    32'd0);
        chk({tag, "_done"},    {31'd0, done},    32'd0);
        chk({tag, "_diff"},    {16'd0, diff},    32'd0);
        chk({tag, "_neg"},     {31'd0, neg},     32'd0);
        chk({tag, "_invalid"}, {31'd0, invalid}, 32'd0);
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        issue(16'h0042, 16'h0017, 16'h0025, 1'b0, 1'b0, 6,  1'b1); wait_idle();
        issue(16'h0017, 16'h0042, 16'h0025, 1'b1, 1'b0, 10, 1'b1); wait_idle();
        issue(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 6,  1'b1); wait_idle();
        issue(16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 10, 1'b1); wait_idle();
        issue(16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b0, 6,  1'b1); wait_idle();
        issue(16'h0001, 16'h1000, 16'h0999, 1'b1, 1'b0, 10, 1'b1); wait_idle();

        // Invalid operand, then a valid start must clear invalid immediately.
        issue(16'h00A3, 16'h0001, 16'h0000, 1'b0, 1'b1, 2,  1'b1); wait_idle();
        issue(16'h0042, 16'h0017, 16'h0025, 1'b0, 1'b0, 6,  1'b1);
        @(negedge clk);
        chk("inv_cleared", {31'd0, invalid}, 32'd0);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wait_idle();

        // start during SUB with different operands is ignored.
        issue(16'h0042, 16'h0017, 16'h0025, 1'b0, 1'b0, 6,  1'b1);
        @(posedge clk); @(posedge clk); #1;
        a = 16'h9999; b = 16'h0000; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle();

        // start in the DONE cycle is ignored, accepted one cycle later in IDLE.
        issue(16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0, 6,  1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (!done && k < 20);
        chk("done_seen", {31'd0, done}, 32'd1);
        a = 16'h0002; b = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
        begin
            exp_t e;
            @(posedge clk);
            e.diff = 16'h0002; e.neg = 1'b0; e.inv = 1'b0; e.lat = 6; e.t0 = $time;
            sb_q.push_back(e);
            #1 start = 1'b0;
        end
        wait_idle();

        // Reset during the NEG pass: everything clears and no done appears.
        issue(16'h0017, 16'h0042, 16'h0000, 1'b0, 1'b0, 0,  1'b0);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("mid_reset");
        repeat (15) @(negedge clk);
        issue(16'h0017, 16'h0042, 16'h0025, 1'b1, 1'b0, 10, 1'b1); wait_idle();
        issue(16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 6,  1'b1); wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
